sign_mag_acc_ctrl: RTL and testbench
====================================

Name: sign_mag_acc_ctrl

Overview:
Sequencer that sums a batch of sign-magnitude operands, one operand per accepted transfer.
- A length-tagged start command opens the batch; operands then arrive on a valid/ready stream.
- Each operand is folded into a registered accumulator by an internal sign-magnitude adder.
- The final sum and a sticky overflow flag are presented on a valid/ready result port.
- Sits between an operand source and a result consumer in the arithmetic datapath.

Parameters:
N, 8, operand/result width: bit N-1 = sign, bits N-2:0 = magnitude.
CNT_W, 4, width of the batch-length field; max batch = 2^CNT_W - 1 operands.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  batch start command; sampled only in IDLE.
len  input  CNT_W  operand count for the batch; sampled with start.
busy  output  1  high in ACC and HOLD.
in_data  input  N  sign-magnitude operand.
in_valid  input  1  operand valid.
in_ready  output  1  operand accepted when in_valid & in_ready.
out_sum  output  N  sign-magnitude batch sum.
out_ovf  output  1  sticky magnitude overflow for the batch.
out_valid  output  1  result valid.
out_ready  input  1  result consumed when out_valid & out_ready.

Behaviour:
- Clock and reset: one clock domain, clk; reset is asynchronous and active-high.
- Reset forces:
  - state = IDLE, accumulator = 0, ovf = 0, remaining = 0.
  - busy = 0, in_ready = 0, out_valid = 0, out_sum = 0, out_ovf = 0.
  - An in-flight batch is discarded with no partial result.
- Moore outputs, decoded from state:
  - in_ready = (state == ACC).
  - out_valid = (state == HOLD).
  - busy = (state != IDLE).
  - out_sum and out_ovf are driven directly from the accumulator and ovf registers.
- IDLE:
  - start=1, len>0: acc <= 0, ovf <= 0, remaining <= len, go to ACC.
  - start=1, len=0: acc <= 0, ovf <= 0, go directly to HOLD; out_valid rises on the next cycle.
  - start=0: stay in IDLE.
- ACC, on each in_valid & in_ready:
  - acc <= smadd(acc, in_data).
  - ovf <= ovf | carry.
  - remaining <= remaining - 1.
  - If remaining == 1, go to HOLD.
  - With no transfer, all state holds.
- HOLD:
  - out_sum and out_ovf stay stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready -> IDLE, with out_valid dropping the next cycle.
  - A start asserted in ACC or HOLD is ignored and not queued.
- Latency: the result is valid 1 cycle after the last operand is accepted. Throughput is 1 operand per cycle.
- smadd(a, b), combinational, magnitude width M = N-1:
  - Equal signs: mag = a.mag + b.mag, computed in M+1 bits. carry = bit M. Result mag = low M bits (wraps). Result sign = common sign.
  - Different signs: the larger magnitude supplies the sign. mag = larger - smaller. carry = 0.
  - Equal magnitudes: sign is taken from b before normalization.
  - Zero normalization: a result magnitude of 0 always produces sign 0 (no -0 output). Both +0 and -0 inputs are accepted as zero.
- ovf is sticky across the batch. After ovf is set, later operands still update acc with the wrapped arithmetic.
- An operand presented while in_ready=0 is not consumed. The source must hold it.

Test Plan:
- Mixed-sign batch (N=8): len=3, operands 0x05 (+5), 0x83 (-3), 0x87 (-7), sent back-to-back -> out_valid rises 1 cycle after the third accept; out_sum = 0x85 (-5), out_ovf = 0.
- Overflow: len=2, operands 0x64 (+100), 0x32 (+50) -> out_sum = 0x16 (wrapped 150-128 = 22), out_ovf = 1. The following batch len=1, operand 0x01 -> out_sum = 0x01, out_ovf = 0 (flag cleared at start).
- Zero cancellation: len=2, operands 0x09, 0x89 -> out_sum = 0x00, never 0x80, out_ovf = 0. Also len=1, operand 0x80 -> 0x00.
- Empty batch: start with len=0 -> busy=1 and out_valid=1 on the next cycle; out_sum = 0x00; in_ready stays 0 throughout.
- Backpressure:
  - len=2 with in_valid low for 3 cycles between operands -> remaining holds and no extra accepts occur.
  - out_ready held low 5 cycles in HOLD, with a start pulse of len=4 -> out_sum and out_valid stay stable and the start is ignored.
  - out_ready=1 -> IDLE on the next cycle.
- Reset mid-batch: len=3, accept 0x05, then assert reset for 1 cycle -> all outputs 0 and state IDLE. A new batch len=1 with operand 0x02 -> out_sum = 0x02.

Source files
------------

// File: rtl/sign_mag_acc_ctrl.sv
// Batch accumulator for sign-magnitude operands: a length-tagged start opens a batch, operands
// stream in over valid/ready, and the sum plus a sticky overflow flag are offered on a result port.
module sign_mag_acc_ctrl #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned M = N - 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic         a_sgn, b_sgn, res_sgn, carry;
  logic [M-1:0] a_mag, b_mag, res_mag;
  logic [M:0]   mag_sum;

  assign a_sgn   = acc_q[N-1];
  assign a_mag   = acc_q[M-1:0];
  assign b_sgn   = in_data[N-1];
  assign b_mag   = in_data[M-1:0];
  assign mag_sum = {1'b0, a_mag} + {1'b0, b_mag};

  // smadd(acc, in_data); a zero magnitude is always forced positive so -0 never escapes.
  always_comb begin
    res_sgn = 1'b0;
    res_mag = '0;
    carry   = 1'b0;
    if (a_sgn == b_sgn) begin
      res_mag = mag_sum[M-1:0];
      carry   = mag_sum[M];
      res_sgn = a_sgn;
    end else if (a_mag > b_mag) begin
      res_mag = a_mag - b_mag;
      res_sgn = a_sgn;
    end else begin
      res_mag = b_mag - a_mag;
      res_sgn = b_sgn;
    end
    if (res_mag == '0) begin
      res_sgn = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            rem_d   = len;
            state_d = StAcc;
          end else begin
            state_d = StHold;
          end
        end
      end
      StAcc: begin
        if (in_valid) begin
          acc_d = {res_sgn, res_mag};
          ovf_d = ovf_q | carry;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sign_mag_acc_ctrl.sv
// Directed bench for sign_mag_acc_ctrl: hand-computed batch sums, overflow, zero
// normalisation, empty batch, back-pressure on both ports and mid-batch reset.
module tb_sign_mag_acc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic       busy;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       out_valid;
  logic       out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  sign_mag_acc_ctrl #(
    .N     (8),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int k = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    check("in_ready_wait", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic take_result(input string tag, input logic [7:0] sum, input logic ovf);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_sum"}, 32'(out_sum), 32'(sum));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drop"}, 32'(out_valid), 0);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(out_sum), 0);
    check("rst_ovf", 32'(out_ovf), 0);
    reset = 1'b0;
    step();

    // +5, -3, -7 -> -5
    start_batch(4'd3);
    check("mix_busy", 32'(busy), 1);
    check("mix_in_ready", 32'(in_ready), 1);
    send(8'h05);
    send(8'h83);
    check("mix_not_done", 32'(out_valid), 0);
    send(8'h87);
    take_result("mix", 8'h85, 1'b0);

    // 100 + 50 wraps to 22 with overflow
    start_batch(4'd2);
    send(8'h64);
    send(8'h32);
    take_result("ovf", 8'h16, 1'b1);

    // Empty batch: clears the previous sum and flag, never opens the operand port
    in_valid = 1'b1;
    in_data  = 8'h11;
    start_batch(4'd0);
    check("empty_busy", 32'(busy), 1);
    check("empty_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    take_result("empty", 8'h00, 1'b0);

    start_batch(4'd1);
    send(8'h01);
    take_result("after_ovf", 8'h01, 1'b0);

    // +9 + -9 must be +0
    start_batch(4'd2);
    send(8'h09);
    send(8'h89);
    take_result("cancel", 8'h00, 1'b0);

    start_batch(4'd1);
    send(8'h80);
    take_result("neg_zero", 8'h00, 1'b0);

    // Input stall between operands
    start_batch(4'd2);
    send(8'h10);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready", 32'(in_ready), 1);
      check("stall_out_valid", 32'(out_valid), 0);
    end
    send(8'h20);
    check("bp_valid", 32'(out_valid), 1);

    // Output stall with an ignored start
    for (int i = 0; i < 5; i++) begin
      start = (i == 0);
      len   = 4'd4;
      step();
      start = 1'b0;
      check("hold_valid", 32'(out_valid), 1);
      check("hold_sum", 32'(out_sum), 'h30);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    take_result("bp", 8'h30, 1'b0);
    step();
    check("start_not_queued", 32'(busy), 0);

    // Reset in the middle of a batch
    start_batch(4'd3);
    send(8'h05);
    reset = 1'b1;
    #2;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_sum", 32'(out_sum), 0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_valid", 32'(out_valid), 0);
    start_batch(4'd1);
    send(8'h02);
    take_result("post_rst", 8'h02, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
